// File: rtl/pocket_video_pkg.sv
// Shared types and slot-word field placement for the Pocket video output stage.
package pocket_video_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  typedef struct packed {
    rgb24_t rgb;
    logic   hs;
    logic   vs;
    logic   de;
  } vid_sig_t;

  localparam int SLOT_LSB = 13;
  localparam int SLOT_W   = 3;

endpackage

// File: rtl/sync_pulse_gen.sv
// Turns a level-type sync into a one-cycle pulse on its rising edge.
module sync_pulse_gen (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic pulse_o
);

  logic sig_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sig_q <= 1'b0;
    else       sig_q <= sig_i;
  end

  assign pulse_o = sig_i & ~sig_q;

endmodule

// File: rtl/video_output_formatter.sv
// Final video stage: sync pulses, blanking, frame statistics.
// Define VIDOUT_SLOT_WORD_EN to drive the scaler-slot word on the first blanking cycle of each line.
module video_output_formatter
  import pocket_video_pkg::*;
#(
  parameter int PIPE_DLY = 2,
  parameter int W_CNT    = 12
) (
  input  logic              clk_vid,
  input  logic              reset,
  input  logic [23:0]       in_rgb,
  input  logic              in_hs,
  input  logic              in_vs,
  input  logic              in_de,
  input  logic [SLOT_W-1:0] slot_sel,
  output logic [23:0]       vid_rgb,
  output logic              vid_hs,
  output logic              vid_vs,
  output logic              vid_de,
  output logic [W_CNT-1:0]  stat_width,
  output logic [W_CNT-1:0]  stat_lines,
  output logic              stat_valid
);

  localparam logic [W_CNT-1:0] CNT_MAX = '1;

  // Stage 0 is the input register; the output register supplies the final stage of latency.
  vid_sig_t dly_q [PIPE_DLY];
  vid_sig_t src;
  genvar    gi;

  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) dly_q[0] <= '0;
    else       dly_q[0] <= {in_rgb, in_hs, in_vs, in_de};
  end

  for (gi = 1; gi < PIPE_DLY; gi++) begin : g_dly
    always_ff @(posedge clk_vid or posedge reset) begin
      if (reset) dly_q[gi] <= '0;
      else       dly_q[gi] <= dly_q[gi-1];
    end
  end

  assign src = dly_q[PIPE_DLY-1];

`ifdef VIDOUT_SLOT_WORD_EN
  logic [SLOT_W-1:0] slot_q [PIPE_DLY];

  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) slot_q[0] <= '0;
    else       slot_q[0] <= slot_sel;
  end

  for (gi = 1; gi < PIPE_DLY; gi++) begin : g_slot
    always_ff @(posedge clk_vid or posedge reset) begin
      if (reset) slot_q[gi] <= '0;
      else       slot_q[gi] <= slot_q[gi-1];
    end
  end
`else
  logic unused_slot;
  assign unused_slot = ^slot_sel;
`endif

  logic hs_rise, vs_rise, de_fall;

  sync_pulse_gen u_hs_pulse (.clk_i(clk_vid), .rst_i(reset), .sig_i(src.hs), .pulse_o(hs_rise));
  sync_pulse_gen u_vs_pulse (.clk_i(clk_vid), .rst_i(reset), .sig_i(src.vs), .pulse_o(vs_rise));

  logic             de_prev_q;
  logic [23:0]      vid_rgb_q, vid_rgb_d;
  logic             vid_hs_q, vid_vs_q, vid_de_q;
  logic [W_CNT-1:0] width_cnt_q, width_cnt_d, width_last_q, width_last_d;
  logic [W_CNT-1:0] line_cnt_q, line_cnt_d;
  logic [W_CNT-1:0] stat_width_q, stat_width_d, stat_lines_q, stat_lines_d;
  logic             stat_valid_q, stat_valid_d, armed_q, armed_d;

  assign de_fall = de_prev_q & ~src.de;

  always_comb begin
    vid_rgb_d = src.de ? src.rgb : 24'h0;
`ifdef VIDOUT_SLOT_WORD_EN
    if (de_fall) vid_rgb_d[SLOT_LSB +: SLOT_W] = slot_q[PIPE_DLY-1];
`endif
  end

  // A DE fall in the same cycle as a VS rise belongs to the frame being closed.
  always_comb begin
    width_cnt_d  = width_cnt_q;
    width_last_d = width_last_q;
    line_cnt_d   = line_cnt_q;
    stat_width_d = stat_width_q;
    stat_lines_d = stat_lines_q;
    stat_valid_d = 1'b0;
    armed_d      = armed_q;
    if (src.de && width_cnt_q != CNT_MAX) width_cnt_d = width_cnt_q + 1'b1;
    if (de_fall) begin
      width_last_d = width_cnt_q;
      width_cnt_d  = '0;
      if (line_cnt_q != CNT_MAX) line_cnt_d = line_cnt_q + 1'b1;
    end
    if (vs_rise) begin
      if (armed_q) begin
        stat_width_d = width_last_d;
        stat_lines_d = line_cnt_d;
        stat_valid_d = 1'b1;
      end
      line_cnt_d = '0;
      armed_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      de_prev_q    <= 1'b0;
      vid_rgb_q    <= '0;
      vid_hs_q     <= 1'b0;
      vid_vs_q     <= 1'b0;
      vid_de_q     <= 1'b0;
      width_cnt_q  <= '0;
      width_last_q <= '0;
      line_cnt_q   <= '0;
      stat_width_q <= '0;
      stat_lines_q <= '0;
      stat_valid_q <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      de_prev_q    <= src.de;
      vid_rgb_q    <= vid_rgb_d;
      vid_hs_q     <= hs_rise;
      vid_vs_q     <= vs_rise;
      vid_de_q     <= src.de;
      width_cnt_q  <= width_cnt_d;
      width_last_q <= width_last_d;
      line_cnt_q   <= line_cnt_d;
      stat_width_q <= stat_width_d;
      stat_lines_q <= stat_lines_d;
      stat_valid_q <= stat_valid_d;
      armed_q      <= armed_d;
    end
  end

  assign vid_rgb    = vid_rgb_q;
  assign vid_hs     = vid_hs_q;
  assign vid_vs     = vid_vs_q;
  assign vid_de     = vid_de_q;
  assign stat_width = stat_width_q;
  assign stat_lines = stat_lines_q;
  assign stat_valid = stat_valid_q;

endmodule
